// File: rtl/fp_div_iter_pkg.sv
// Shared definitions for the iterative single-precision divider: width and
// constant macros (the archerdefs set), FSM state encodings, the operand
// classification record and a float packing helper.
// Optional feature macro: FDIV_FLAGS_EN (adds the {NV,DZ,OF,UF,NX} flags port).
`ifndef ARCHERDEFS_V
`define ARCHERDEFS_V
`define XLEN          32
`define FP_CANON_NAN  32'h7FC00000
`define FP_BIAS       127
`define FDIV_ITERS    25
`define FDIV_LATENCY  26
`define FLAG_NV       4
`define FLAG_DZ       3
`define FLAG_OF       2
`define FLAG_UF       1
`define FLAG_NX       0
`endif

package fp_div_iter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DIVIDE  = 2'd1;
    localparam logic [1:0] ST_NORM    = 2'd2;
    localparam logic [1:0] ST_SPECIAL = 2'd3;

    // Last iteration index of the restoring divide loop.
    localparam logic [4:0] LAST_ITER = 5'(`FDIV_ITERS - 1);

    // Unpacked view of one IEEE-754 single operand.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;     // hidden bit included
        logic        is_zero;  // exponent 0: zeros and flushed denormals
        logic        is_inf;
        logic        is_nan;
    } fp_class_t;

    // Assemble a single-precision word from its fields.
    function automatic logic [31:0] pack_fp(input logic sign,
                                            input logic [7:0] exp,
                                            input logic [22:0] mant);
        return {sign, exp, mant};
    endfunction

endpackage

// File: rtl/fp_div_iter_classify.sv
// fp_classify: combinational unpack of one single-precision operand into sign,
// exponent, mantissa with hidden bit and zero/inf/NaN class. Denormals are
// treated as zero (flush-to-zero), matching the FPU.
import fp_div_iter_pkg::*;

module fp_classify (
    input  logic [31:0] op,
    output fp_class_t   cls
);

    // Split the fields and derive the operand class.
    always_comb begin
        cls.sign    = op[31];
        cls.exp     = op[30:23];
        cls.mant    = {1'b1, op[22:0]};
        cls.is_zero = (op[30:23] == 8'h00);
        cls.is_inf  = (op[30:23] == 8'hFF) && (op[22:0] == 23'h000000);
        cls.is_nan  = (op[30:23] == 8'hFF) && (op[22:0] != 23'h000000);
    end

endmodule

// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative fdiv.s beside the combinational FPU. Restoring
// division, one quotient bit per cycle (25 iterations), then a normalise
// cycle; special operands take a one-cycle fast path. Truncation rounding,
// flush-to-zero, canonical NaN.
// Optional feature macro: FDIV_FLAGS_EN adds the 5-bit {NV,DZ,OF,UF,NX}
// flags output; result, busy, done and latency are the same either way.
import fp_div_iter_pkg::*;

module fp_div_iter (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [`XLEN-1:0]  inputA,
    input  logic [`XLEN-1:0]  inputB,
    output logic              busy,
    output logic              done,
    output logic [`XLEN-1:0]  result
`ifdef FDIV_FLAGS_EN
    ,
    output logic [4:0]        flags
`endif
);

    fp_class_t cls_a_s;
    fp_class_t cls_b_s;

    fp_classify u_cls_a (.op(inputA), .cls(cls_a_s));
    fp_classify u_cls_b (.op(inputB), .cls(cls_b_s));

    logic [1:0]         state_q,    state_d;
    logic [4:0]         cnt_q,      cnt_d;
    logic [24:0]        rem_q,      rem_d;
    logic [23:0]        divisor_q,  divisor_d;
    logic [24:0]        quo_q,      quo_d;
    logic signed [9:0]  exp_q,      exp_d;
    logic               sign_q,     sign_d;
    logic [31:0]        spec_res_q, spec_res_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [31:0]        result_q,   result_d;

    logic               special_s;
    logic [31:0]        spec_val_s;
    logic [31:0]        norm_val_s;
    logic [24:0]        rem_sub_s;
    logic               qbit_s;
    logic signed [9:0]  exp_norm_s;
    logic [22:0]        mant_norm_s;
    logic               inexact_s;

`ifdef FDIV_FLAGS_EN
    logic [4:0]         spec_flags_q, spec_flags_d;
    logic [4:0]         flags_q,      flags_d;
    logic [4:0]         spec_fl_s;
    logic [4:0]         norm_fl_s;
`endif

    // Fast-path decision and value for the operands presented with start.
    always_comb begin
        logic nan_s;
        logic sgn_s;
        nan_s = cls_a_s.is_nan | cls_b_s.is_nan
              | (cls_a_s.is_zero & cls_b_s.is_zero)
              | (cls_a_s.is_inf & cls_b_s.is_inf);
        sgn_s = cls_a_s.sign ^ cls_b_s.sign;
        special_s = nan_s | cls_a_s.is_inf | cls_b_s.is_inf
                  | cls_a_s.is_zero | cls_b_s.is_zero;
        spec_val_s = 32'h00000000;
`ifdef FDIV_FLAGS_EN
        spec_fl_s = 5'b00000;
`endif
        if (nan_s) begin
            spec_val_s = `FP_CANON_NAN;
`ifdef FDIV_FLAGS_EN
            spec_fl_s[`FLAG_NV] = 1'b1;
`endif
        end else if (cls_a_s.is_inf) begin
            spec_val_s = pack_fp(sgn_s, 8'hFF, 23'h000000);
        end else if (cls_b_s.is_zero) begin
            spec_val_s = pack_fp(sgn_s, 8'hFF, 23'h000000);
`ifdef FDIV_FLAGS_EN
            spec_fl_s[`FLAG_DZ] = 1'b1;
`endif
        end else if (cls_a_s.is_zero | cls_b_s.is_inf) begin
            spec_val_s = pack_fp(sgn_s, 8'h00, 23'h000000);
        end else begin
            spec_val_s = 32'h00000000;
        end
    end

    // One restoring-division step: trial subtract of the divisor.
    always_comb begin
        if (rem_q >= {1'b0, divisor_q}) begin
            rem_sub_s = rem_q - {1'b0, divisor_q};
            qbit_s    = 1'b1;
        end else begin
            rem_sub_s = rem_q;
            qbit_s    = 1'b0;
        end
    end

    // Normalise the 25-bit quotient (q[24] has weight 1) and range-check.
    always_comb begin
        logic lost_s;
        if (quo_q[24]) begin
            mant_norm_s = quo_q[23:1];
            exp_norm_s  = exp_q;
            lost_s      = quo_q[0];
        end else begin
            mant_norm_s = quo_q[22:0];
            exp_norm_s  = exp_q - 10'sd1;
            lost_s      = 1'b0;
        end
        inexact_s = lost_s | (rem_q != 25'h0000000);
`ifdef FDIV_FLAGS_EN
        norm_fl_s = 5'b00000;
`endif
        if (exp_norm_s >= 10'sd255) begin
            norm_val_s = pack_fp(sign_q, 8'hFF, 23'h000000);
`ifdef FDIV_FLAGS_EN
            norm_fl_s[`FLAG_OF] = 1'b1;
            norm_fl_s[`FLAG_NX] = 1'b1;
`endif
        end else if (exp_norm_s <= 10'sd0) begin
            norm_val_s = pack_fp(sign_q, 8'h00, 23'h000000);
`ifdef FDIV_FLAGS_EN
            norm_fl_s[`FLAG_UF] = 1'b1;
            norm_fl_s[`FLAG_NX] = 1'b1;
`endif
        end else begin
            norm_val_s = pack_fp(sign_q, exp_norm_s[7:0], mant_norm_s);
`ifdef FDIV_FLAGS_EN
            norm_fl_s[`FLAG_NX] = inexact_s;
`endif
        end
    end

    // Sequencer: accept, iterate, normalise or take the fast path.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        quo_d      = quo_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        spec_res_d = spec_res_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
`ifdef FDIV_FLAGS_EN
        spec_flags_d = spec_flags_q;
        flags_d      = flags_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    sign_d = cls_a_s.sign ^ cls_b_s.sign;
                    if (special_s) begin
                        state_d    = ST_SPECIAL;
                        spec_res_d = spec_val_s;
`ifdef FDIV_FLAGS_EN
                        spec_flags_d = spec_fl_s;
`endif
                    end else begin
                        state_d   = ST_DIVIDE;
                        cnt_d     = 5'd0;
                        rem_d     = {1'b0, cls_a_s.mant};
                        divisor_d = cls_b_s.mant;
                        quo_d     = 25'h0000000;
                        exp_d     = $signed({2'b00, cls_a_s.exp})
                                  - $signed({2'b00, cls_b_s.exp})
                                  + 10'sd127;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                // rem_sub < divisor < 2^24, so the shift never drops a one.
                rem_d = {rem_sub_s[23:0], 1'b0};
                quo_d = {quo_q[23:0], qbit_s};
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_NORM;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_NORM: begin
                result_d = norm_val_s;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
`ifdef FDIV_FLAGS_EN
                flags_d = norm_fl_s;
`endif
            end
            ST_SPECIAL: begin
                result_d = spec_res_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
`ifdef FDIV_FLAGS_EN
                flags_d = spec_flags_q;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            rem_q      <= 25'h0000000;
            divisor_q  <= 24'h000000;
            quo_q      <= 25'h0000000;
            exp_q      <= 10'sd0;
            sign_q     <= 1'b0;
            spec_res_q <= 32'h00000000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 32'h00000000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            quo_q      <= quo_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            spec_res_q <= spec_res_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

`ifdef FDIV_FLAGS_EN
    // Exception flag registers, updated alongside result.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_flags_q <= 5'b00000;
            flags_q      <= 5'b00000;
        end else begin
            spec_flags_q <= spec_flags_d;
            flags_q      <= flags_d;
        end
    end

    assign flags = flags_q;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
